multiport_register_file: RTL and testbench
==========================================

Name: multiport_register_file

Overview:
- Parametrised successor to the 4x16 register file, for the pipelined datapath.
- Provides 2^ADDR_W registers of DATA_W bits, two combinational read ports and two write ports with defined priority.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard, used by the hazard unit to stall on registers that have writes in flight.
- Register 0 is hard-wired to zero.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 2, register-select width; depth = 2^ADDR_W
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports and Busy outputs; 0 = a write becomes visible the cycle after the edge

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset_n  input  1  synchronous, active-low reset
RR1  input  ADDR_W  read-port-1 register select
RR2  input  ADDR_W  read-port-2 register select
RD1  output  DATA_W  read-port-1 data
RD2  output  DATA_W  read-port-2 data
WR1  input  ADDR_W  write-port-1 register select
WD1  input  DATA_W  write-port-1 data
RegWrite1  input  1  write-port-1 enable
WR2  input  ADDR_W  write-port-2 register select
WD2  input  DATA_W  write-port-2 data
RegWrite2  input  1  write-port-2 enable
IssueEn  input  1  marks register IssueReg as pending a write
IssueReg  input  ADDR_W  register being issued
Busy1  output  1  register RR1 is pending
Busy2  output  1  register RR2 is pending

Behaviour:
- Reset: when reset_n=0 at a rising edge, all registers are set to 0 and all pending bits are cleared. During that cycle and after it, RD1/RD2 read 0 and Busy1/Busy2 read 0. Reset overrides every write and issue in the same cycle.
- Write: at the rising edge, a write port with RegWrite=1 and WR!=0 updates Regs[WR].
  - Writes to register 0 are ignored.
  - If both ports target the same register, port 2 wins (port 2 is the younger instruction).
  - Different targets are both written.
- Read: RD = Regs[RR], combinational. RR=0 always returns 0.
- Bypass:
  - BYPASS=1: if a write enabled this cycle targets RR (RR!=0), RD returns that write's data. When both ports match, WD2 is returned.
  - BYPASS=0: RD returns the stored value. Write latency is one edge.
- Scoreboard, one pending bit per register; bit 0 is constant 0.
  - Set at the edge when IssueEn=1 and IssueReg!=0.
  - Cleared at the edge when either write port writes that register.
  - If issue and write hit the same register in the same cycle, set wins (a new write is outstanding).
  - Issue and writes to different registers act independently.
- Busy outputs: Busy = pending[RR].
  - BYPASS=1: Busy is forced to 0 when a write enabled this cycle targets RR, since the data is forwarded.
  - BYPASS=0: Busy reflects stored pending only.
- Wrap-around: none. Addresses are full-range, and all 2^ADDR_W registers are valid.
- Mid-operation reset: a reset asserted in the same cycle as writes or issues discards them. The next cycle shows all zeros and no pending bits.
- Outputs are purely combinational from state and inputs. There is no read latency.

Test Plan:
- Reset: preload Regs[1..3]=16'hAAAA and pending bits, hold reset_n=0 for 1 edge -> RD1/RD2=0 for every RR, Busy1/Busy2=0.
- Basic write/read (BYPASS=0): write WR1=2, WD1=16'h1234 -> RD1(RR1=2)=16'h0000 in the write cycle, 16'h1234 after the edge.
- Bypass (BYPASS=1): in one cycle, WR1=3, WD1=16'h00FF and WR2=3, WD2=16'hBEEF with both enabled and RR1=RR2=3 -> RD1=RD2=16'hBEEF combinationally, Regs[3]=16'hBEEF after the edge.
- Register 0: write WD1=16'hFFFF to WR1=0 and issue IssueReg=0 -> RD(RR=0)=0 and Busy(RR=0)=0 forever.
- Scoreboard: issue reg 1 -> Busy1=1 next cycle. Write reg 1 while issuing reg 1 in the same cycle -> Busy1 stays 1. Write reg 1 alone -> Busy1=0 after the edge, and 0 during that cycle if BYPASS=1.
- Parametrisation: DATA_W=32, ADDR_W=5. Write 32'hDEADBEEF to reg 31, read it back; registers 1..30 remain 0.

Source files
------------

// File: rtl/multiport_register_file.sv
// Parametrised register file: 2^ADDR_W x DATA_W, two combinational read ports,
// two prioritised write ports, optional write-to-read bypass and a per-register
// pending-write scoreboard for the hazard unit. Register 0 reads as zero.
module multiport_register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] WR1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              RegWrite1,
    input  logic [ADDR_W-1:0] WR2,
    input  logic [DATA_W-1:0] WD2,
    input  logic              RegWrite2,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic              Busy1,
    output logic              Busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             pending;

    // Effective write enables: writes aimed at register 0 are dropped here so
    // they neither update storage, clear a pending bit nor get forwarded.
    logic we1, we2, issue;
    assign we1   = RegWrite1 && (WR1 != '0);
    assign we2   = RegWrite2 && (WR2 != '0);
    assign issue = IssueEn && (IssueReg != '0);

    // Storage and scoreboard update; port 2 (younger) wins a same-target write,
    // and a new issue beats a completing write on the same register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (we2 && (WR2 == ADDR_W'(i)))
                    regs[i] <= WD2;
                else if (we1 && (WR1 == ADDR_W'(i)))
                    regs[i] <= WD1;

                if (issue && (IssueReg == ADDR_W'(i)))
                    pending[i] <= 1'b1;
                else if ((we1 && (WR1 == ADDR_W'(i))) || (we2 && (WR2 == ADDR_W'(i))))
                    pending[i] <= 1'b0;
            end
        end
    end

    // Forwarding hits per read port (only meaningful when bypass is enabled).
    logic hit1_w1, hit1_w2, hit2_w1, hit2_w2;
    assign hit1_w1 = we1 && (WR1 == RR1);
    assign hit1_w2 = we2 && (WR2 == RR1);
    assign hit2_w1 = we1 && (WR1 == RR2);
    assign hit2_w2 = we2 && (WR2 == RR2);

    // Read port 1: stored value, optionally forwarded; zero for reg 0 and in reset.
    always_comb begin
        RD1   = regs[RR1];
        Busy1 = pending[RR1];
        if (BYPASS != 0) begin
            if (hit1_w2) begin
                RD1   = WD2;
                Busy1 = 1'b0;
            end else if (hit1_w1) begin
                RD1   = WD1;
                Busy1 = 1'b0;
            end
        end
        if (!reset_n || (RR1 == '0)) begin
            RD1   = '0;
            Busy1 = 1'b0;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        RD2   = regs[RR2];
        Busy2 = pending[RR2];
        if (BYPASS != 0) begin
            if (hit2_w2) begin
                RD2   = WD2;
                Busy2 = 1'b0;
            end else if (hit2_w1) begin
                RD2   = WD1;
                Busy2 = 1'b0;
            end
        end
        if (!reset_n || (RR2 == '0)) begin
            RD2   = '0;
            Busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: a bypassing and a non-bypassing 16x4
// instance share stimulus (directed table, then random against a model), and
// a 32-bit x 32-entry instance gets a short directed sequence.
module tb_multiport_register_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two small instances
    logic        rst_n = 1'b0;
    logic [1:0]  rr1 = '0, rr2 = '0, wr1 = '0, wr2 = '0, ir = '0;
    logic [15:0] wd1 = '0, wd2 = '0;
    logic        we1 = 1'b0, we2 = 1'b0, ie = 1'b0;

    logic [15:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_bz1, b_bz2, n_bz1, n_bz2;

    multiport_register_file #(.DATA_W(16), .ADDR_W(2), .BYPASS(1)) dut_b (
        .clock(clk), .reset_n(rst_n), .RR1(rr1), .RR2(rr2), .RD1(b_rd1), .RD2(b_rd2),
        .WR1(wr1), .WD1(wd1), .RegWrite1(we1), .WR2(wr2), .WD2(wd2), .RegWrite2(we2),
        .IssueEn(ie), .IssueReg(ir), .Busy1(b_bz1), .Busy2(b_bz2));

    multiport_register_file #(.DATA_W(16), .ADDR_W(2), .BYPASS(0)) dut_n (
        .clock(clk), .reset_n(rst_n), .RR1(rr1), .RR2(rr2), .RD1(n_rd1), .RD2(n_rd2),
        .WR1(wr1), .WD1(wd1), .RegWrite1(we1), .WR2(wr2), .WD2(wd2), .RegWrite2(we2),
        .IssueEn(ie), .IssueReg(ir), .Busy1(n_bz1), .Busy2(n_bz2));

    // Wide instance
    logic        w_rst_n = 1'b0;
    logic [4:0]  w_rr1 = '0, w_rr2 = '0, w_wr1 = '0, w_wr2 = '0, w_ir = '0;
    logic [31:0] w_wd1 = '0, w_wd2 = '0;
    logic        w_we1 = 1'b0, w_we2 = 1'b0, w_ie = 1'b0;
    logic [31:0] w_rd1, w_rd2;
    logic        w_bz1, w_bz2;

    multiport_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_w (
        .clock(clk), .reset_n(w_rst_n), .RR1(w_rr1), .RR2(w_rr2), .RD1(w_rd1), .RD2(w_rd2),
        .WR1(w_wr1), .WD1(w_wd1), .RegWrite1(w_we1), .WR2(w_wr2), .WD2(w_wd2), .RegWrite2(w_we2),
        .IssueEn(w_ie), .IssueReg(w_ir), .Busy1(w_bz1), .Busy2(w_bz2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: register contents and pending flags as plain arrays.
    logic [15:0] mregs [4];
    bit          mpend [4];

    function automatic logic [15:0] exp_rd(input bit byp, input logic [1:0] rr);
        if (!rst_n || rr == 2'd0) return 16'h0;
        if (byp && we2 && wr2 == rr) return wd2;
        if (byp && we1 && wr1 == rr) return wd1;
        return mregs[rr];
    endfunction

    function automatic logic exp_bz(input bit byp, input logic [1:0] rr);
        if (!rst_n || rr == 2'd0) return 1'b0;
        if (byp && ((we2 && wr2 == rr) || (we1 && wr1 == rr))) return 1'b0;
        return mpend[rr];
    endfunction

    // Apply one rising edge to the model: writes in program order (port 2 is
    // later so it wins), writes retire pending flags, then a new issue sets one.
    task automatic model_step();
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mregs[i] = '0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (we1 && wr1 != 2'd0) begin mregs[wr1] = wd1; mpend[wr1] = 1'b0; end
            if (we2 && wr2 != 2'd0) begin mregs[wr2] = wd2; mpend[wr2] = 1'b0; end
            if (ie && ir != 2'd0) mpend[ir] = 1'b1;
        end
    endtask

    typedef struct {
        logic        rst_n, we1;
        logic [1:0]  wr1;
        logic [15:0] wd1;
        logic        we2;
        logic [1:0]  wr2;
        logic [15:0] wd2;
        logic        ie;
        logic [1:0]  ir, rr1, rr2;
        logic [15:0] b_rd1, b_rd2;
        logic        b_bz1, b_bz2;
        logic [15:0] n_rd1, n_rd2;
        logic        n_bz1, n_bz2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic e1, input logic [1:0] a1, input logic [15:0] d1,
        input logic e2, input logic [1:0] a2, input logic [15:0] d2,
        input logic i, input logic [1:0] ia, input logic [1:0] q1, input logic [1:0] q2,
        input logic [15:0] br1, input logic [15:0] br2, input logic bb1, input logic bb2,
        input logic [15:0] nr1, input logic [15:0] nr2, input logic nb1, input logic nb2);
        vec_t v;
        v.rst_n = r;  v.we1 = e1; v.wr1 = a1; v.wd1 = d1;
        v.we2 = e2;   v.wr2 = a2; v.wd2 = d2;
        v.ie = i;     v.ir = ia;  v.rr1 = q1; v.rr2 = q2;
        v.b_rd1 = br1; v.b_rd2 = br2; v.b_bz1 = bb1; v.b_bz2 = bb2;
        v.n_rd1 = nr1; v.n_rd2 = nr2; v.n_bz1 = nb1; v.n_bz2 = nb2;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin mregs[i] = '0; mpend[i] = 1'b0; end

        //         rst we1 wr1 wd1      we2 wr2 wd2      ie ir rr1 rr2 | bypass rd1,rd2,bz1,bz2 | no-bypass rd1,rd2,bz1,bz2
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 2, 16'h1234, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 2, 16'h1234, 16'h1234, 0, 0, 16'h1234, 16'h1234, 0, 0));
        tbl.push_back(mk(1, 1, 3, 16'h00FF, 1, 3, 16'hBEEF, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 2, 16'hBEEF, 16'h1234, 0, 0, 16'hBEEF, 16'h1234, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 16'h0000, 16'h0000, 1, 1));
        tbl.push_back(mk(1, 1, 1, 16'h5555, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h5555, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h5555, 16'h5555, 1, 1, 16'h5555, 16'h5555, 1, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h6666, 0, 0, 1, 2, 16'h6666, 16'h1234, 0, 0, 16'h5555, 16'h1234, 1, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 3, 16'h6666, 16'hBEEF, 0, 0, 16'h6666, 16'hBEEF, 0, 0));
        tbl.push_back(mk(1, 1, 3, 16'h0001, 0, 0, 16'h0000, 1, 2, 2, 3, 16'h1234, 16'h0001, 0, 0, 16'h1234, 16'hBEEF, 0, 0));
        tbl.push_back(mk(1, 1, 1, 16'hAAAA, 1, 2, 16'hAAAA, 1, 3, 2, 1, 16'hAAAA, 16'hAAAA, 0, 0, 16'h1234, 16'h6666, 1, 0));
        tbl.push_back(mk(1, 1, 3, 16'hAAAA, 0, 0, 16'h0000, 1, 1, 3, 2, 16'hAAAA, 16'hAAAA, 0, 0, 16'h0001, 16'hAAAA, 1, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 3, 16'hAAAA, 16'hAAAA, 1, 0, 16'hAAAA, 16'hAAAA, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 16'h7777, 1, 2, 1, 3, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));

        // Directed table, one row per cycle
        foreach (tbl[k]) begin
            @(negedge clk);
            rst_n = tbl[k].rst_n; we1 = tbl[k].we1; wr1 = tbl[k].wr1; wd1 = tbl[k].wd1;
            we2 = tbl[k].we2; wr2 = tbl[k].wr2; wd2 = tbl[k].wd2;
            ie = tbl[k].ie; ir = tbl[k].ir; rr1 = tbl[k].rr1; rr2 = tbl[k].rr2;
            #1;
            chk($sformatf("tbl%0d b_rd1", k), b_rd1, tbl[k].b_rd1);
            chk($sformatf("tbl%0d b_rd2", k), b_rd2, tbl[k].b_rd2);
            chk($sformatf("tbl%0d b_bz1", k), b_bz1, tbl[k].b_bz1);
            chk($sformatf("tbl%0d b_bz2", k), b_bz2, tbl[k].b_bz2);
            chk($sformatf("tbl%0d n_rd1", k), n_rd1, tbl[k].n_rd1);
            chk($sformatf("tbl%0d n_rd2", k), n_rd2, tbl[k].n_rd2);
            chk($sformatf("tbl%0d n_bz1", k), n_bz1, tbl[k].n_bz1);
            chk($sformatf("tbl%0d n_bz2", k), n_bz2, tbl[k].n_bz2);
            @(posedge clk);
            model_step();
        end

        // Random stimulus against the model, both bypass modes
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 24) != 0);
            we1 = $urandom_range(0, 1); wr1 = 2'($urandom_range(0, 3)); wd1 = 16'($urandom);
            we2 = $urandom_range(0, 1); wr2 = 2'($urandom_range(0, 3)); wd2 = 16'($urandom);
            ie  = $urandom_range(0, 1); ir  = 2'($urandom_range(0, 3));
            rr1 = 2'($urandom_range(0, 3)); rr2 = 2'($urandom_range(0, 3));
            #1;
            chk($sformatf("rnd%0d b_rd1", c), b_rd1, exp_rd(1'b1, rr1));
            chk($sformatf("rnd%0d b_rd2", c), b_rd2, exp_rd(1'b1, rr2));
            chk($sformatf("rnd%0d b_bz1", c), b_bz1, exp_bz(1'b1, rr1));
            chk($sformatf("rnd%0d b_bz2", c), b_bz2, exp_bz(1'b1, rr2));
            chk($sformatf("rnd%0d n_rd1", c), n_rd1, exp_rd(1'b0, rr1));
            chk($sformatf("rnd%0d n_rd2", c), n_rd2, exp_rd(1'b0, rr2));
            chk($sformatf("rnd%0d n_bz1", c), n_bz1, exp_bz(1'b0, rr1));
            chk($sformatf("rnd%0d n_bz2", c), n_bz2, exp_bz(1'b0, rr2));
            @(posedge clk);
            model_step();
        end

        // Wide instance: reset, write reg 31 while issuing reg 30
        @(negedge clk);
        w_rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        w_rst_n = 1'b1;
        w_we1 = 1'b1; w_wr1 = 5'd31; w_wd1 = 32'hDEADBEEF;
        w_ie = 1'b1;  w_ir = 5'd30;
        w_rr1 = 5'd31; w_rr2 = 5'd30;
        #1;
        chk("w bypass rd1", w_rd1, 32'hDEADBEEF);
        chk("w bypass bz2", w_bz2, 32'h0);
        @(posedge clk);
        @(negedge clk);
        w_we1 = 1'b0; w_ie = 1'b0;
        #1;
        chk("w rd1 r31", w_rd1, 32'hDEADBEEF);
        chk("w rd2 r30", w_rd2, 32'h0);
        chk("w bz2 r30", w_bz2, 32'h1);
        chk("w bz1 r31", w_bz1, 32'h0);
        for (int r = 0; r <= 30; r++) begin
            @(negedge clk);
            w_rr1 = 5'(r);
            #1;
            chk($sformatf("w rd1 r%0d", r), w_rd1, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
